// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants, field helpers and types for the hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Registers an FD instruction reads, each with a qualifier.
  typedef struct packed {
    logic       rs_vld;
    logic [4:0] rs;
    logic       rt_vld;
    logic [4:0] rt;
    logic       rd_vld;
    logic [4:0] rd;
  } rd_set_t;

  // Control outputs, kept together so reset gating is a single assignment.
  typedef struct packed {
    logic stall_pc;
    logic stall_fd;
    logic stall_dx;
    logic nop_dx;
    logic nop_xm;
    logic flush_fd;
    logic ctrl_mult;
    logic ctrl_div;
    logic md_capture;
    logic md_exc;
    logic md_timeout;
    logic md_busy;
  } ctrl_out_t;

  function automatic logic [4:0] get_op(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] ir);
    return ir[26:22];
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] ir);
    return ir[21:17];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] ir);
    return ir[16:12];
  endfunction

  function automatic logic [4:0] get_aluop(input logic [31:0] ir);
    return ir[6:2];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are the controller's outputs.
interface hazard_ctrl_if;

  logic [31:0] fd_out_ir;
  logic [31:0] dx_out_ir;
  logic        ctrl_taken;
  logic        md_result_ready;
  logic        md_exception;

  logic        stall_pc;
  logic        stall_fd;
  logic        stall_dx;
  logic        nop_dx;
  logic        nop_xm;
  logic        flush_fd;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        md_capture;
  logic        md_exc;
  logic        md_timeout;
  logic        md_busy;

  // Controller side: observes pipeline state, drives stall/flush/multdiv controls.
  modport master (
    input  fd_out_ir, dx_out_ir, ctrl_taken, md_result_ready, md_exception,
    output stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd,
    output ctrl_mult, ctrl_div, md_capture, md_exc, md_timeout, md_busy
  );

  // Pipeline side.
  modport slave (
    output fd_out_ir, dx_out_ir, ctrl_taken, md_result_ready, md_exception,
    input  stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd,
    input  ctrl_mult, ctrl_div, md_capture, md_exc, md_timeout, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_decode.sv
// Instruction decode for hazard detection: DX lw/multdiv flags, FD read set.
// Latency: combinational.
// Backpressure: none.
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  output logic        dx_is_lw,
  output logic        dx_is_md,
  output logic        dx_is_mul,
  output logic [4:0]  dx_rd,
  output rd_set_t     fd_rd_set
);

  logic [4:0] dx_op;
  logic [4:0] dx_alu;
  logic [4:0] fd_op;
  logic       fd_is_jump;
  logic       unused_bits;

  assign dx_op  = get_op(dx_ir);
  assign dx_alu = get_aluop(dx_ir);
  assign fd_op  = get_op(fd_ir);

  // Opcodes whose register fields are target bits, not sources; jr is
  // handled separately through its rd read.
  assign fd_is_jump = (fd_op == OP_J) || (fd_op == OP_JAL) ||
                      (fd_op == OP_JR) || (fd_op == OP_BEX);

  // DX-side decode flags.
  always_comb begin
    dx_is_lw  = (dx_op == OP_LW);
    dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
    dx_is_md  = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
    dx_rd     = get_rd(dx_ir);
  end

  // FD read set; sw's rd is its store data and is served by forwarding, so it is not listed.
  always_comb begin
    fd_rd_set        = '0;
    fd_rd_set.rs_vld = !fd_is_jump;
    fd_rd_set.rs     = get_rs(fd_ir);
    fd_rd_set.rt_vld = (fd_op == OP_RTYPE);
    fd_rd_set.rt     = get_rt(fd_ir);
    fd_rd_set.rd_vld = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);
    fd_rd_set.rd     = get_rd(fd_ir);
  end

  assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: load-use bubble, multdiv sequencing, branch flush.
// Latency: outputs combinational from inputs and FSM state; one state register.
// Backpressure: holds PC/FD/DX while a multdiv runs, up to MD_TIMEOUT cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.master bus
);

  state_t     state;
  state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  ctrl_out_t  o;

  logic       dx_is_lw;
  logic       dx_is_md;
  logic       dx_is_mul;
  logic [4:0] dx_rd;
  rd_set_t    fd_rd_set;
  logic       load_use;

  hazard_decode u_decode (
    .fd_ir     (bus.fd_out_ir),
    .dx_ir     (bus.dx_out_ir),
    .dx_is_lw  (dx_is_lw),
    .dx_is_md  (dx_is_md),
    .dx_is_mul (dx_is_mul),
    .dx_rd     (dx_rd),
    .fd_rd_set (fd_rd_set)
  );

  // Load-use: FD reads the register a DX load is still fetching; r0 never stalls.
  always_comb begin
    load_use = dx_is_lw && (dx_rd != 5'd0) &&
               ((fd_rd_set.rs_vld && (fd_rd_set.rs == dx_rd)) ||
                (fd_rd_set.rt_vld && (fd_rd_set.rt == dx_rd)) ||
                (fd_rd_set.rd_vld && (fd_rd_set.rd == dx_rd)));
  end

  // State and wait counter; reset abandons any multdiv in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and control outputs.
  always_comb begin
    o         = '0;
    state_nxt = state;
    cnt_nxt   = cnt;

    // A taken redirect squashes FD and DX; it cannot arrive while RUN holds X.
    o.flush_fd = bus.ctrl_taken;
    o.nop_dx   = bus.ctrl_taken;

    case (state)
      ST_IDLE: begin
        // A multdiv in DX being squashed by the redirect must not be started.
        if (dx_is_md && !bus.ctrl_taken) begin
          o.ctrl_mult = dx_is_mul;
          o.ctrl_div  = !dx_is_mul;
          o.stall_pc  = 1'b1;
          o.stall_fd  = 1'b1;
          o.stall_dx  = 1'b1;
          o.nop_xm    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_RUN;
        end else if (load_use && !bus.ctrl_taken) begin
          o.stall_pc = 1'b1;
          o.stall_fd = 1'b1;
          o.nop_dx   = 1'b1;
        end
      end
      ST_RUN: begin
        o.md_busy = 1'b1;
        if (bus.md_result_ready) begin
          // Result goes into X/M and the pipeline advances in this same cycle.
          o.md_capture = 1'b1;
          o.md_exc     = bus.md_exception;
          state_nxt    = ST_IDLE;
        end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
          // Give up: the multdiv retires as a bubble into X/M.
          o.md_timeout = 1'b1;
          o.nop_xm     = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          o.stall_pc = 1'b1;
          o.stall_fd = 1'b1;
          o.stall_dx = 1'b1;
          o.nop_xm   = 1'b1;
          cnt_nxt    = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are quiet while reset is held so the pipeline sees no stray pulse.
  always_comb begin
    {bus.stall_pc, bus.stall_fd, bus.stall_dx, bus.nop_dx, bus.nop_xm, bus.flush_fd,
     bus.ctrl_mult, bus.ctrl_div, bus.md_capture, bus.md_exc, bus.md_timeout,
     bus.md_busy} = reset ? '0 : o;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with an expected-value queue.
// Latency: one check per clock, sampled mid-cycle.
// Backpressure: n/a.
module tb_hazard_ctrl;

  logic clock;
  logic reset;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (hif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector bit masks, MSB first.
  localparam logic [11:0] O_SPC  = 12'h800;
  localparam logic [11:0] O_SFD  = 12'h400;
  localparam logic [11:0] O_SDX  = 12'h200;
  localparam logic [11:0] O_NDX  = 12'h100;
  localparam logic [11:0] O_NXM  = 12'h080;
  localparam logic [11:0] O_FL   = 12'h040;
  localparam logic [11:0] O_MUL  = 12'h020;
  localparam logic [11:0] O_DIV  = 12'h010;
  localparam logic [11:0] O_CAP  = 12'h008;
  localparam logic [11:0] O_EXC  = 12'h004;
  localparam logic [11:0] O_TO   = 12'h002;
  localparam logic [11:0] O_BSY  = 12'h001;
  localparam logic [11:0] O_HOLD = O_SPC | O_SFD | O_SDX | O_NXM;
  localparam logic [11:0] O_LU   = O_SPC | O_SFD | O_NDX;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_to = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input logic [4:0] alu);
    logic [31:0] ir;
    ir = {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'd0, alu, 2'b00};
    return ir;
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, input int rd, input int rs, input int imm);
    logic [31:0] ir;
    ir = {op, 5'(rd), 5'(rs), 17'(imm)};
    return ir;
  endfunction

  function automatic logic [11:0] observed();
    return {hif.stall_pc, hif.stall_fd, hif.stall_dx, hif.nop_dx, hif.nop_xm, hif.flush_fd,
            hif.ctrl_mult, hif.ctrl_div, hif.md_capture, hif.md_exc, hif.md_timeout, hif.md_busy};
  endfunction

  task automatic step(input logic [31:0] dx, input logic [31:0] fd, input logic taken,
                      input logic rdy, input logic exc, input logic rst,
                      input logic [11:0] exp_v, input string tag);
    logic [11:0] obs;
    logic [11:0] e;
    string       t;
    @(posedge clock);
    #1;
    hif.dx_out_ir       = dx;
    hif.fd_out_ir       = fd;
    hif.ctrl_taken      = taken;
    hif.md_result_ready = rdy;
    hif.md_exception    = exc;
    reset               = rst;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    #2;
    obs = observed();
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    n_cmp++;
    assert (!(hif.ctrl_taken && hif.md_busy)) else begin
      n_err++;
      $error("FAIL %s_taken_in_run: observed busy=%b taken=%b required not both", t, hif.md_busy, hif.ctrl_taken);
    end
    if (hif.ctrl_mult || hif.ctrl_div) n_start++;
    if (hif.md_timeout) n_to++;
  endtask

  task automatic check_count(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [31:0] nop;
    logic [31:0] lw5;
    logic [31:0] lw0;
    logic [31:0] add_rs5;
    logic [31:0] mul3;
    logic [31:0] div4;
    int s0;
    int t0;

    nop     = 32'h0;
    lw5     = i_type(5'b01000, 5, 2, 0);
    lw0     = i_type(5'b01000, 0, 2, 0);
    add_rs5 = r_type(6, 5, 1, 5'b00000);
    mul3    = r_type(3, 1, 2, 5'b00110);
    div4    = r_type(4, 1, 2, 5'b00111);

    reset = 1'b1;
    hif.dx_out_ir = '0;
    hif.fd_out_ir = '0;
    hif.ctrl_taken = 1'b0;
    hif.md_result_ready = 1'b0;
    hif.md_exception = 1'b0;

    step(nop, nop, 0, 0, 0, 1, '0, "in_reset");
    step(nop, nop, 0, 0, 0, 1, '0, "in_reset2");
    step(nop, nop, 0, 0, 0, 0, '0, "after_reset");

    // Load-use detection over the read-set variants.
    step(lw5, add_rs5, 0, 0, 0, 0, O_LU, "lu_rs");
    step(nop, add_rs5, 0, 0, 0, 0, '0, "lu_bubble_gone");
    step(lw5, r_type(6, 1, 5, 5'b00000), 0, 0, 0, 0, O_LU, "lu_rt");
    step(lw0, r_type(6, 0, 1, 5'b00000), 0, 0, 0, 0, '0, "lu_r0");
    step(lw5, i_type(5'b00111, 5, 3, 0), 0, 0, 0, 0, '0, "lu_sw_data");
    step(lw5, i_type(5'b00111, 1, 5, 0), 0, 0, 0, 0, O_LU, "lu_sw_base");
    step(lw5, i_type(5'b00010, 5, 1, 0), 0, 0, 0, 0, O_LU, "lu_bne_rd");
    step(lw5, i_type(5'b00110, 5, 1, 0), 0, 0, 0, 0, O_LU, "lu_blt_rd");
    step(lw5, i_type(5'b00100, 5, 0, 0), 0, 0, 0, 0, O_LU, "lu_jr_rd");
    step(lw5, i_type(5'b00001, 5, 5, 0), 0, 0, 0, 0, '0, "lu_j_none");
    step(lw5, i_type(5'b10110, 5, 5, 32'h5000), 0, 0, 0, 0, '0, "lu_bex_none");
    step(lw5, i_type(5'b00101, 6, 5, 0), 0, 0, 0, 0, O_LU, "lu_addi_rs");
    step(lw5, i_type(5'b00101, 6, 1, 32'h5000), 0, 0, 0, 0, '0, "lu_addi_imm");
    step(lw5, i_type(5'b00101, 5, 1, 0), 0, 0, 0, 0, '0, "lu_addi_rd_only");

    // Branch flush, alone and overriding a load-use.
    step(nop, nop, 1, 0, 0, 0, O_FL | O_NDX, "flush_plain");
    step(lw5, add_rs5, 1, 0, 0, 0, O_FL | O_NDX, "flush_over_lu");

    // mul with result at cycle 17.
    s0 = n_start;
    step(mul3, add_rs5, 0, 0, 0, 0, O_HOLD | O_MUL, "mul_c0");
    for (int c = 1; c <= 16; c++)
      step(mul3, add_rs5, 0, 0, 0, 0, O_HOLD | O_BSY, $sformatf("mul_c%0d", c));
    step(mul3, add_rs5, 0, 1, 0, 0, O_CAP | O_BSY, "mul_c17");
    step(add_rs5, nop, 0, 0, 0, 0, '0, "mul_c18");
    check_count("mul_starts", n_start - s0, 1);

    // div then mul back-to-back, exception on the first capture.
    s0 = n_start;
    step(div4, mul3, 0, 0, 0, 0, O_HOLD | O_DIV, "b2b_div_start");
    for (int c = 1; c <= 3; c++)
      step(div4, mul3, 0, 0, 0, 0, O_HOLD | O_BSY, $sformatf("b2b_div_c%0d", c));
    step(div4, mul3, 0, 1, 1, 0, O_CAP | O_EXC | O_BSY, "b2b_div_cap");
    step(mul3, nop, 0, 0, 0, 0, O_HOLD | O_MUL, "b2b_mul_start");
    step(mul3, nop, 0, 0, 0, 0, O_HOLD | O_BSY, "b2b_mul_c1");
    step(mul3, nop, 0, 0, 0, 0, O_HOLD | O_BSY, "b2b_mul_c2");
    step(mul3, nop, 0, 1, 0, 0, O_CAP | O_BSY, "b2b_mul_cap");
    step(nop, nop, 0, 1, 1, 0, '0, "idle_ready_ignored");
    check_count("b2b_starts", n_start - s0, 2);

    // div timeout after 40 cycles.
    t0 = n_to;
    step(div4, nop, 0, 0, 0, 0, O_HOLD | O_DIV, "to_c0");
    for (int c = 1; c <= 39; c++)
      step(div4, nop, 0, 0, 0, 0, O_HOLD | O_BSY, $sformatf("to_c%0d", c));
    step(div4, nop, 0, 0, 0, 0, O_TO | O_NXM | O_BSY, "to_c40");
    step(nop, nop, 0, 0, 0, 0, '0, "to_c41_idle");
    check_count("to_pulses", n_to - t0, 1);

    // Reset at cycle 10 abandons a div; no timeout afterwards.
    t0 = n_to;
    step(div4, nop, 0, 0, 0, 0, O_HOLD | O_DIV, "rst_c0");
    for (int c = 1; c <= 9; c++)
      step(div4, nop, 0, 0, 0, 0, O_HOLD | O_BSY, $sformatf("rst_c%0d", c));
    step(div4, nop, 0, 0, 0, 1, '0, "rst_c10");
    for (int c = 11; c <= 45; c++)
      step(nop, nop, 0, 0, 0, 0, '0, $sformatf("rst_c%0d", c));
    check_count("rst_no_timeout", n_to - t0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline. It covers the hazard cases that operand forwarding into X cannot resolve.
- Detects load-use hazards between the FD and DX stages and inserts a one-cycle bubble.
- Sequences multi-cycle mult/div operations sitting in DX: start pulse, pipeline hold, result capture.
- Flushes FD and DX on a taken branch or jump resolved in X.

Parameters:
- MD_TIMEOUT, 40: maximum number of cycles to wait for md_result_ready before aborting.
- CNT_W, 6: width of the wait counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  input  1  pipeline clock; rising edge.
- reset  input  1  synchronous, active-high.
- fd_out_ir  input  32  instruction in the F/D latch.
- dx_out_ir  input  32  instruction in the D/X latch.
- ctrl_taken  input  1  X-stage branch/jump redirect this cycle.
- md_result_ready  input  1  multdiv result valid.
- md_exception  input  1  multdiv exception, qualified by md_result_ready.
- stall_pc  output  1  hold the PC.
- stall_fd  output  1  hold the F/D latch.
- stall_dx  output  1  hold the D/X latch.
- nop_dx  output  1  load a nop into D/X.
- nop_xm  output  1  load a nop into X/M.
- flush_fd  output  1  load a nop into F/D.
- ctrl_mult  output  1  one-cycle multiply start.
- ctrl_div  output  1  one-cycle divide start.
- md_capture  output  1  latch the multdiv result into X/M.
- md_exc  output  1  capture carries an exception; writeback targets r30.
- md_timeout  output  1  one-cycle abort pulse.
- md_busy  output  1  FSM is in RUN.

Behaviour:
- Field decode:
  - opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12], aluop = ir[6:2].
  - mul: opcode 00000 with aluop 00110. div: opcode 00000 with aluop 00111.
  - lw opcode 01000; sw 00111; bne 00010; blt 00110; jr 00100; bex 10110.
- Reset: state IDLE, counter 0, every output 0 in the cycle following the reset edge. A reset in RUN abandons the operation; no capture and no timeout pulse are produced.
- FSM states: IDLE, RUN.
- IDLE, with a mul or div in DX:
  - Pulse ctrl_mult or ctrl_div for exactly this cycle.
  - Assert stall_pc, stall_fd, stall_dx and nop_xm.
  - Clear the counter and go to RUN.
- RUN, md_result_ready = 0:
  - Keep the four stall/nop outputs asserted and increment the counter.
  - When the counter reaches MD_TIMEOUT-1: pulse md_timeout, release the stalls that cycle, let the DX instruction retire as a nop (nop_xm stays 1), go to IDLE.
- RUN, md_result_ready = 1:
  - Pulse md_capture; md_exc = md_exception.
  - Deassert all stalls and nop_xm so the pipeline advances that cycle. Go to IDLE.
  - A mul/div now arriving in DX is started on the next cycle, giving back-to-back operation.
  - md_result_ready while in IDLE is ignored.
- No ctrl_mult/ctrl_div pulse ever occurs in RUN.
- Load-use hazard, combinational, active only in IDLE with no mul/div in DX. Fires when DX is lw, its rd != 0, and the FD instruction reads that register:
  - rs for any non-jump opcode;
  - rt for R-type;
  - rd for bne, blt, jr.
  - A sw whose data register (rd) equals the lw rd does not stall; that case is covered by writeback-to-memory forwarding.
  - Response: stall_pc = stall_fd = 1 and nop_dx = 1 for exactly one cycle.
- Branch flush: ctrl_taken = 1 gives flush_fd = 1 and nop_dx = 1, and overrides the load-use stall (stall_pc = stall_fd = 0 that cycle).
  - ctrl_taken cannot coincide with RUN, because the branch occupies X only after a mul/div has left. The bench asserts this never happens.
- Register 0 never causes a stall.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_BEX;
  - ALU-op constants ALU_MUL and ALU_DIV;
  - field-slice functions for rd, rs, rt;
  - the state enumeration.
- One sub-module, hazard_decode: purely combinational. It produces the is_lw, is_md, is_mul decode flags and the FD read-register set.
- The FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: DX = lw r5,0(r2); FD = add r6,r5,r1 -> one cycle with stall_pc = stall_fd = nop_dx = 1, then 0.
- lw r0 in DX; FD = add r6,r0,r1 -> no stall. sw r5 behind lw r5 (data register) -> no stall.
- mul r3,r1,r2 in DX:
  - cycle 0: ctrl_mult = 1 and all stalls = 1.
  - md_result_ready asserted at cycle 17 -> md_capture = 1 and stalls = 0 at cycle 17; md_busy = 1 for cycles 1-16.
- div in DX immediately followed by mul -> ctrl_div pulse, capture, then ctrl_mult on the very next cycle; exactly two start pulses total.
- div with md_result_ready held low -> md_timeout pulses at cycle 40 after the start, then IDLE. A reset asserted at cycle 10 instead -> IDLE, all outputs 0, no timeout pulse.
- ctrl_taken = 1 in the same cycle as a load-use condition -> flush_fd = nop_dx = 1 and stall_pc = 0.
